// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int WORD_BYTES     = 4;
    localparam int BYTE_OFS_LSB   = 0;
    localparam int BYTE_OFS_MSB   = 1;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int WAIT_CNT_W     = 4;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous per-lane write, combinational read.
// Latency: read is same-cycle; write lands at the next rising clk edge.
// Backpressure: none; the caller guarantees at most one access per cycle.
module mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic [WORD_BYTES-1:0] i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Byte-lane writes; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus memory responder: one request at a time, WAIT_STATES wait cycles, one-cycle MemReady.
// Latency: MemReady arrives WAIT_STATES+1 cycles after the accept cycle; a request occupies WAIT_STATES+2 cycles.
// Backpressure: MemReq is only sampled in IDLE; Busy stays high from accept through the response cycle.
// Optional: DATA_MEM_BYTE_STROBE_EN adds ByteEnable[3:0] lane strobes and allows byte-unaligned addresses.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReq,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
`ifdef DATA_MEM_BYTE_STROBE_EN
    input  logic [WORD_BYTES-1:0] ByteEnable,
`endif
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReady,
    output logic                  AddrError,
    output logic                  Busy
);

    // Counter value on WAIT entry; unused when there are no wait states.
    localparam logic [WAIT_CNT_W-1:0] LP_WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_t              r_state;
    mem_state_t              w_next;
    logic                    w_accept;
    logic [WAIT_CNT_W-1:0]   r_cnt;
    logic                    r_write;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [WORD_BYTES-1:0]   r_lanes;
    logic [WORD_BYTES-1:0]   w_lanes_in;
    logic                    w_misalign;
    logic                    w_oor;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [WORD_BYTES-1:0]   w_we;

`ifdef DATA_MEM_BYTE_STROBE_EN
    assign w_lanes_in = ByteEnable;
    assign w_misalign = 1'b0;
`else
    assign w_lanes_in = '1;
    assign w_misalign = (r_addr[BYTE_OFS_MSB:BYTE_OFS_LSB] != '0);
`endif

    // Upper address bits beyond the storage are an error, never aliased.
    assign w_oor = |r_addr[31:ADDR_WIDTH+2];
    assign w_err = w_misalign | w_oor;
    assign w_idx = r_addr[ADDR_WIDTH+1:2];

    // FSM state register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the accept strobe.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemReq) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= LP_WAIT_LOAD;
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Request capture; later input changes cannot disturb an accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lanes <= '0;
        end else if (w_accept) begin
            r_write <= MemWrite;
            r_addr  <= Address;
            r_wdata <= WriteData;
            r_lanes <= w_lanes_in;
        end
    end

    // Response outputs and the store commit, all decoded from the RESP state.
    always_comb begin
        MemReady  = 1'b0;
        AddrError = 1'b0;
        ReadData  = '0;
        Busy      = (r_state != IDLE);
        w_we      = '0;
        if (r_state == RESP) begin
            MemReady  = 1'b1;
            AddrError = w_err;
            if (!w_err) begin
                // Stores also return the pre-write word.
                ReadData = w_rdata;
                if (r_write) begin
                    w_we = r_lanes;
                end
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) share one request stream.
// Latency: each response is checked against the accept cycle plus WAIT_STATES+1.
// Backpressure: requests are only issued once both responders report not Busy.
`timescale 1ns/1ps
module tb_data_mem_responder;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReq = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
`ifdef DATA_MEM_BYTE_STROBE_EN
    logic [3:0]  ByteEnable = '0;
`endif

    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, err2, err0, busy2, busy0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .MemReq(MemReq), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .ByteEnable(ByteEnable),
`endif
        .ReadData(rd2), .MemReady(rdy2), .AddrError(err2), .Busy(busy2)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .MemReq(MemReq), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .ByteEnable(ByteEnable),
`endif
        .ReadData(rd0), .MemReady(rdy0), .AddrError(err0), .Busy(busy0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;   // index of the cycle in which MemReq was sampled
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [31:0] model [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idx_list [8] = '{0, 1, 4, 5, 8, 100, 511, 1023};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor for the 2-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("busy2", busy2, q2.size() != 0);
            if (rdy2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_rdy2", rdy2, 0);
                end else begin
                    e = q2.pop_front();
                    chk("rdata2", rd2, e.rdata);
                    chk("err2", err2, e.err);
                    chk("lat2", cyc - e.acc, 3);
                end
            end else begin
                chk("err2_no_rdy", err2, 0);
            end
        end
    end

    // Monitor for the 0-wait-state responder.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("busy0", busy0, q0.size() != 0);
            if (rdy0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_rdy0", rdy0, 0);
                end else begin
                    e = q0.pop_front();
                    chk("rdata0", rd0, e.rdata);
                    chk("err0", err0, e.err);
                    chk("lat0", cyc - e.acc, 1);
                end
            end else begin
                chk("err0_no_rdy", err0, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with both responders idle.
    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("idle_timeout", {busy2, busy0}, 0);
    endtask

    // Issue one request, scramble the bus after accept, push the expected response.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit commit);
        exp_t        e;
        bit          err;
        int          idx;
        logic [31:0] old;
        logic [3:0]  lanes;
        wait_idle();
        MemReq = 1'b1; MemWrite = wr; Address = a; WriteData = d;
`ifdef DATA_MEM_BYTE_STROBE_EN
        ByteEnable = be;
        lanes = be;
`else
        lanes = 4'hF;
`endif
        @(posedge clk); #1;
        MemReq = 1'b0; MemWrite = 1'($urandom); Address = $urandom; WriteData = $urandom;
`ifdef DATA_MEM_BYTE_STROBE_EN
        ByteEnable = 4'($urandom);
`endif
        // Reference rules: out-of-range if any bit above the word index is set;
        // misaligned only when byte strobes are not built in.
        err = (a >> (AW + 2)) != 0;
`ifndef DATA_MEM_BYTE_STROBE_EN
        if (a % 4 != 0) err = 1'b1;
`endif
        idx = int'((a >> 2) % (1 << AW));
        old = err ? 32'h0 : model[idx];
        e.rdata = old;
        e.err   = err;
        e.acc   = cyc - 1;
        q2.push_back(e);
        q0.push_back(e);
        if (wr && !err && commit) begin
            for (int i = 0; i < 4; i++)
                if (lanes[i]) old[8*i +: 8] = d[8*i +: 8];
            model[idx] = old;
        end
    endtask

    // Store, then pull reset one cycle after accept: nothing may commit.
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, a, d, 4'hF, 1'b0);
        #6;
        chk("dut0_resp_before_rst", q0.size(), 0);
        rst = 1'b0;
        q2.delete();
        #1;
        chk("rst_rdata2", rd2, 0);   chk("rst_rdy2", rdy2, 0);
        chk("rst_err2", err2, 0);    chk("rst_busy2", busy2, 0);
        chk("rst_rdata0", rd0, 0);   chk("rst_rdy0", rdy0, 0);
        chk("rst_busy0", busy0, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        #1 rst = 1'b0;
        #2;
        chk("reset_rdata2", rd2, 0);  chk("reset_rdy2", rdy2, 0);
        chk("reset_err2", err2, 0);   chk("reset_busy2", busy2, 0);
        chk("reset_rdata0", rd0, 0);  chk("reset_rdy0", rdy0, 0);
        chk("reset_err0", err0, 0);   chk("reset_busy0", busy0, 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Give every word the bench touches a known value.
        foreach (idx_list[i]) issue(1'b1, 32'(idx_list[i]) << 2, $urandom, 4'hF, 1'b1);

        // Directed cases.
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
        issue(1'b1, 32'h0000_0013, 32'h5555_AAAA, 4'hF, 1'b1);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
        issue(1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b1);
        issue(1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 1'b1);
        abort_store(32'h0000_0010, 32'h1234_5678);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1);
`ifdef DATA_MEM_BYTE_STROBE_EN
        issue(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1);
        issue(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1);
        issue(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 1'b1);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1);
`endif

        // Randomised traffic over the known words plus error addresses.
        for (int n = 0; n < 200; n++) begin
            a = 32'(idx_list[$urandom_range(0, 7)]) << 2;
            k = $urandom_range(0, 9);
            if (k == 6 || k == 7) a[1:0] = 2'($urandom_range(1, 3));
            else if (k >= 8) a[AW + 2 + $urandom_range(0, 31 - AW - 2)] = 1'b1;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(1'($urandom), a, $urandom, 4'($urandom), 1'b1);
            if (n == 100) abort_store(a & 32'h0000_0FFC, $urandom);
        end

        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        chk("drain_q2", q2.size(), 0);
        chk("drain_q0", q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the ARM core's data bus. It is the opposite end of the MemWrite/address/write-data interface the processor controller drives.
- Accepts one load/store request at a time, inserts a programmable number of wait states, then returns read data with a one-cycle ready pulse.
- Backs the word-addressed data RAM that holds histogram bins and pixel buffers for the equalization program.

Parameters:
- ADDR_WIDTH, 10, word-index width; storage depth = 2**ADDR_WIDTH 32-bit words.
- DATA_WIDTH, 32, data bus width; fixed at 32 for the ARM core.
- WAIT_STATES, 2, cycles spent in WAIT before the response; legal range 0..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemReq  in  1  request valid; sampled only in IDLE.
- MemWrite  in  1  1 = store, 0 = load; captured with MemReq.
- Address  in  32  byte address; bits [ADDR_WIDTH+1:2] index the storage.
- WriteData  in  32  store data; captured with MemReq.
- ReadData  out  32  load result; valid only while MemReady=1.
- MemReady  out  1  one-cycle response strobe.
- AddrError  out  1  valid with MemReady; flags a misaligned or out-of-range request.
- Busy  out  1  high from accept until the response cycle, inclusive.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - MemReady=0, AddrError=0, Busy=0, ReadData=0, wait counter=0.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If MemReq=1, capture MemWrite, Address and WriteData into request registers. Busy=1 from the next cycle.
  - Go to WAIT if WAIT_STATES>0, else go directly to RESP.
  - If MemReq=0, stay in IDLE.
- WAIT:
  - Counter loads WAIT_STATES-1 on entry and decrements each cycle.
  - Go to RESP when the counter equals 0.
  - MemReq is ignored in WAIT.
- RESP, lasting exactly one cycle:
  - MemReady=1.
  - Loads: ReadData = storage[captured index].
  - Stores: the write commits at the clock edge that leaves RESP. ReadData shows the pre-write word (read-before-write).
  - Next state is always IDLE, so back-to-back requests carry a one-cycle IDLE bubble.
- Latency: accept edge to MemReady = WAIT_STATES+1 cycles. Each request occupies WAIT_STATES+2 cycles.
- Error condition (AddrError=1 during RESP): captured Address[1:0]≠0, or Address[31:ADDR_WIDTH+2]≠0.
  - On error, a store is suppressed and ReadData=0.
  - AddrError=0 whenever MemReady=0.
- Captured request registers are immune to input changes after accept.
- Reset asserted in WAIT or RESP: the request is aborted, no write commits, and the outputs take their reset values immediately.
- Index arithmetic: no wrap-around; any out-of-range address is an error, never aliased.

Optional Feature:
- Macro: DATA_MEM_BYTE_STROBE_EN.
- Defined:
  - Adds input ByteEnable[3:0], captured with MemReq.
  - A store updates only the byte lanes with ByteEnable[i]=1 (lane i = bits 8i+7:8i).
  - ByteEnable=0000 on a store is a legal no-op, with MemReady=1 and AddrError=0.
  - Byte addresses with Address[1:0]≠0 are legal and are not flagged as misaligned.
- Undefined:
  - No ByteEnable port; stores write the full word.
  - Address[1:0]≠0 is an error.

Decomposition:
- Package data_mem_pkg holds:
  - enum mem_state_t {IDLE, WAIT, RESP};
  - WORD_BYTES=4;
  - localparams for the byte-offset field [1:0];
  - the ADDR_WIDTH default.
- Sub-module mem_array: synchronous-write storage with combinational read, and per-lane write enables when byte strobes are compiled in.
- data_mem_responder keeps the FSM, the wait counter, the capture registers and the error check.

Test Plan:
- WAIT_STATES=2: store 0xDEADBEEF @0x00000010, then load @0x10 → store MemReady 3 cycles after accept; load returns ReadData=0xDEADBEEF, AddrError=0.
- WAIT_STATES=0: load accepted in IDLE → MemReady on the very next cycle, Busy high for exactly 1 cycle.
- Store to 0x00000013 (misaligned) with the macro undefined → MemReady=1, AddrError=1; a subsequent load @0x10 still returns the prior value.
- Load @0x00001000 with ADDR_WIDTH=10 (out of range) → AddrError=1, ReadData=0; no aliasing to index 0.
- Store accepted, then WriteData/Address toggled and rst pulsed low during WAIT → outputs drop to 0 at once; a later load of that address returns the old word.
- Macro defined: word 0x11223344 @0x20, then store 0xAABBCCDD with ByteEnable=0101 → load returns 0x11BB33DD.
